// File: rtl/calyx_main_pkg.sv
// Shared types and default constants for the calyx_main Fibonacci component.
// Enum ordering is arbitrary; only the names are referenced by the design.
package calyx_main_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOOP,
        WRITE,
        DONE
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_ITERS = 10;

endpackage

// File: rtl/calyx_std_reg.sv
// Calyx-style register: loads in when write_en is high and raises done
// one cycle after each write.
module calyx_std_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             write_en,
    output logic [WIDTH-1:0] out,
    output logic             done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            done <= 1'b0;
        end else begin
            if (write_en) begin
                out <= in;
            end
            done <= write_en;
        end
    end

endmodule

// File: rtl/calyx_main.sv
// Iterative Fibonacci component with go/done handshake.
// Define CALYX_MAIN_OBS_EN to expose result_o and busy_o.
module calyx_main
    import calyx_main_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITERS = DEFAULT_ITERS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    output logic             done
`ifdef CALYX_MAIN_OBS_EN
    ,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
`endif
);

    localparam int IW = (ITERS > 0) ? $clog2(ITERS + 1) : 1;
    localparam logic [IW-1:0] LAST = IW'((ITERS > 0) ? ITERS - 1 : 0);

    state_e          state;
    logic [IW-1:0]   i;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] result;
    logic            ab_en;
    logic            res_en;
    logic            a_done;
    logic            b_done;
    logic            unused_done;

    assign ab_en  = (state == INIT) || (state == LOOP);
    assign res_en = (state == WRITE);
    assign a_in   = (state == INIT) ? '0 : b;
    assign b_in   = (state == INIT) ? WIDTH'(1) : a + b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state <= INIT;
                    end
                end
                INIT: begin
                    i     <= '0;
                    state <= (ITERS > 0) ? LOOP : WRITE;
                end
                LOOP: begin
                    i <= i + 1'b1;
                    if (i == LAST) begin
                        state <= WRITE;
                    end
                end
                WRITE: state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    calyx_std_reg #(.WIDTH(WIDTH)) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (a_in),
        .write_en (ab_en),
        .out      (a),
        .done     (a_done)
    );

    calyx_std_reg #(.WIDTH(WIDTH)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (b_in),
        .write_en (ab_en),
        .out      (b),
        .done     (b_done)
    );

    // The result write happens only in WRITE, so its delayed done lands
    // exactly on the DONE-state cycle.
    calyx_std_reg #(.WIDTH(WIDTH)) u_result (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (a),
        .write_en (res_en),
        .out      (result),
        .done     (done)
    );

    assign unused_done = a_done ^ b_done;

`ifdef CALYX_MAIN_OBS_EN
    assign result_o = result;
    assign busy_o   = (state != IDLE);
`endif

endmodule

// File: tb/tb_calyx_main.sv
// Directed self-checking bench for calyx_main across three configurations.
module tb_calyx_main;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go0 = 1'b0;
    logic go1 = 1'b0;
    logic go2 = 1'b0;
    logic done0;
    logic done1;
    logic done2;
    logic [2:0] dn;

    int vectors = 0;
    int miscompares = 0;

`ifdef CALYX_MAIN_OBS_EN
    logic [31:0] res_o0;
    logic [7:0]  res_o1;
    logic [31:0] res_o2;
    logic        busy0;
    logic        busy1;
    logic        busy2;
`endif

    always #5 clk = ~clk;

    assign dn = {done2, done1, done0};

    calyx_main #(.WIDTH(32), .ITERS(10)) d0 (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go0),
        .done  (done0)
`ifdef CALYX_MAIN_OBS_EN
        ,
        .result_o (res_o0),
        .busy_o   (busy0)
`endif
    );

    calyx_main #(.WIDTH(8), .ITERS(14)) d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go1),
        .done  (done1)
`ifdef CALYX_MAIN_OBS_EN
        ,
        .result_o (res_o1),
        .busy_o   (busy1)
`endif
    );

    calyx_main #(.WIDTH(32), .ITERS(0)) d2 (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go2),
        .done  (done2)
`ifdef CALYX_MAIN_OBS_EN
        ,
        .result_o (res_o2),
        .busy_o   (busy2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // n = number of rising edges (first one is the go-sampling edge)
    // until done is observed high just after an edge.
    task automatic wait_done(input int idx, input int max,
                             output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            @(posedge clk);
            #1;
            n++;
            if (dn[idx]) seen = 1'b1;
        end
    endtask

    initial begin
        int  n;
        bit  seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done0", {31'b0, done0}, 32'd0);
        chk("rst_done1", {31'b0, done1}, 32'd0);
        chk("rst_done2", {31'b0, done2}, 32'd0);
        chk("rst_result0", d0.result, 32'd0);
`ifdef CALYX_MAIN_OBS_EN
        chk("rst_busy0", {31'b0, busy0}, 32'd0);
        chk("rst_res_o0", res_o0, 32'd0);
`endif

        // Run 1..3: go held high on the 32-bit, ITERS=10 instance.
        @(negedge clk);
        rst_n = 1'b1;
        go0 = 1'b1;
        wait_done(0, 40, n, seen);
        chk("run1_seen", {31'b0, seen}, 32'd1);
        chk("run1_latency", n, 32'd13);
        chk("run1_result", d0.result, 32'd55);
`ifdef CALYX_MAIN_OBS_EN
        chk("run1_busy", {31'b0, busy0}, 32'd1);
        chk("run1_res_o", res_o0, 32'd55);
`endif
        for (int r = 2; r <= 3; r++) begin
            @(posedge clk);
            #1;
            chk($sformatf("run%0d_pulse_width", r - 1), {31'b0, done0}, 32'd0);
            wait_done(0, 40, n, seen);
            chk($sformatf("run%0d_seen", r), {31'b0, seen}, 32'd1);
            chk($sformatf("run%0d_period", r), n + 1, 32'd14);
            chk($sformatf("run%0d_result", r), d0.result, 32'd55);
        end

        // Drop go during DONE: no further run may start.
        @(negedge clk);
        go0 = 1'b0;
        wait_done(0, 30, n, seen);
        chk("held_stop_no_done", {31'b0, seen}, 32'd0);

        // Single-cycle go pulse.
        @(negedge clk);
        go0 = 1'b1;
        @(posedge clk);
        #1;
        go0 = 1'b0;
        wait_done(0, 40, n, seen);
        chk("pulse_seen", {31'b0, seen}, 32'd1);
        chk("pulse_latency", n + 1, 32'd13);
        chk("pulse_result", d0.result, 32'd55);
        wait_done(0, 30, n, seen);
        chk("pulse_no_rerun", {31'b0, seen}, 32'd0);

        // 8-bit wraparound: F(14)=377 -> 121.
        @(negedge clk);
        go1 = 1'b1;
        @(posedge clk);
        #1;
        go1 = 1'b0;
        wait_done(1, 40, n, seen);
        chk("wrap_seen", {31'b0, seen}, 32'd1);
        chk("wrap_latency", n + 1, 32'd17);
        chk("wrap_result", {24'b0, d1.result}, 32'd121);

        // ITERS=0: loop skipped.
        @(negedge clk);
        go2 = 1'b1;
        @(posedge clk);
        #1;
        go2 = 1'b0;
        wait_done(2, 20, n, seen);
        chk("zero_seen", {31'b0, seen}, 32'd1);
        chk("zero_latency", n + 1, 32'd3);
        chk("zero_result", d2.result, 32'd0);
        @(posedge clk);
        #1;
        chk("zero_pulse_width", {31'b0, done2}, 32'd0);

        // Reset asserted in LOOP with i=4 (five edges after sampling edge).
        @(negedge clk);
        go0 = 1'b1;
        @(posedge clk);
        #1;
        go0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_i_before", {28'b0, d0.i}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("abort_result", d0.result, 32'd0);
        chk("abort_done", {31'b0, done0}, 32'd0);
        wait_done(0, 15, n, seen);
        chk("abort_no_done", {31'b0, seen}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        go0 = 1'b1;
        @(posedge clk);
        #1;
        go0 = 1'b0;
        wait_done(0, 40, n, seen);
        chk("after_abort_seen", {31'b0, seen}, 32'd1);
        chk("after_abort_latency", n + 1, 32'd13);
        chk("after_abort_result", d0.result, 32'd55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
